scan_select_seq: RTL and testbench
==================================

# scan_select_seq

Sequential select generator placed directly upstream of the 2-to-4 `DECODER`. It drives the decoder's 2-bit `A` input through all four codes, holding each for a programmable dwell time, so the decoder's one-hot `I` output scans four loads such as display digits or row strobes. Start/stop control, an enable-based pause, and per-step/per-wrap strobes let surrounding logic synchronise to the scan.

## Interface
- `DWELL_W`, default 8: width of the dwell programming input and the internal dwell counter.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `start`  in  1  single-cycle request to begin scanning; sampled only in IDLE.
- `stop`  in  1  single-cycle request to end scanning; sampled only in RUN.
- `en`  in  1  advance enable in RUN; 0 freezes the scan (pause).
- `dwell`  in  DWELL_W  dwell value; each code is held for dwell+1 enabled cycles. Latched when `start` is accepted.
- `sel`  out  2  select code; connects to the decoder's `A`.
- `step`  out  1  one-cycle pulse, high in the cycle `sel` takes a new code.
- `wrap`  out  1  one-cycle pulse, high in the cycle `sel` returns to the first code.
- `busy`  out  1  high while in RUN.

## Operation
- FSM has two states: IDLE and RUN.
- The scan uses a 2-bit index `idx` (0..3), a dwell counter `cnt` (DWELL_W bits), and a latched dwell `dwell_q`. `sel` is a registered output equal to `code(idx)`.
- **IDLE:**
  - `sel`=00, `idx`=0, `cnt`=0, `busy`=0.
  - `start`=1 → RUN; `dwell_q`←`dwell`.
  - `stop` is ignored.
  - `en` is don't-care.
- **RUN:**
  - `busy`=1.
  - If `stop`=1: → IDLE on that edge; `sel`←00, `idx`←0, `cnt`←0, no `step`/`wrap` pulse. `stop` has priority over advancing.
  - Else if `en`=0: all state holds, and `step`/`wrap` are 0.
  - Else if `cnt`==`dwell_q`: `cnt`←0, `idx`←`idx`+1 (mod 4), `sel`←`code(idx+1)`, `step`←1. Also `wrap`←1 when `idx` goes 3→0.
  - Else: `cnt`←`cnt`+1.
  - `start` is ignored; `dwell` is not re-latched mid-scan.
- `cnt` never exceeds `dwell_q`, so there is no counter overflow. With `dwell`=0 the code advances on every enabled cycle.
- `step` and `wrap` are registered, and are cleared on any cycle where the advance condition is false.

## Timing
- Reset values: `sel`=00, `step`=0, `wrap`=0, `busy`=0. Internally the FSM is in IDLE with `cnt`=0, `idx`=0, `dwell_q`=0.
- Reset asserted mid-scan returns everything to the reset values immediately, without waiting for a clock edge.
- Start latency:
  - `start` sampled at edge E → `busy`=1 after E.
  - First code (00) is held for `dwell`+1 enabled cycles.
  - First `step` is at edge E+`dwell`+1 (when `en`=1 throughout).
- Period: one full scan is 4×(`dwell`+1) enabled cycles. `wrap` occurs once per period, coincident with a `step`.
- Stop takes effect in 1 cycle: `busy`=0 and `sel`=00 after the sampling edge.
- Pause: each cycle with `en`=0 stretches the current dwell by exactly one cycle.
- Simultaneous `start`+`stop`: in IDLE, start wins; in RUN, stop wins.

## Configuration
- Macro: `SCAN_GRAY_EN`.
- Defined: `code(idx)` follows the Gray order 00→01→11→10→00, so only one bit of `sel` toggles per step (glitch-safe into the decoder).
- Undefined: `code(idx)` = `idx`, i.e. binary order 00→01→10→11→00.
- All timing and handshakes are identical in both builds.

## Structure
- Shared package `scan_select_pkg` holds:
  - FSM state constants `ST_IDLE`, `ST_RUN`;
  - the first-code constant `SEL_FIRST`=2'b00;
  - the four Gray code constants.
- One natural sub-module: `scan_code_map`, a purely combinational mapping from `idx` to `code`. It contains the `SCAN_GRAY_EN` selection so the FSM file stays macro-free.

## Test plan
- **Reset:** assert `rst` mid-scan with `sel`=11 → `sel`=00, `busy`=0, `step`=0, `wrap`=0 immediately; with `rst` held, clock edges change nothing.
- **Gray scan:** `SCAN_GRAY_EN` defined, `dwell`=3, `start` pulse, `en`=1 → `sel` is 00,01,11,10,00, each held 4 cycles; `step` at cycles 4,8,12,16; `wrap` only at 16.
- **Binary scan:** macro undefined, `dwell`=0 → `sel` is 00,01,10,11,00 on consecutive cycles; `step` high continuously; `wrap` every 4th cycle.
- **Pause:** `dwell`=2, drop `en` for 5 cycles mid-dwell → the current code is held 3+5=8 cycles and `cnt` resumes where it stopped; no pulses during the pause.
- **Stop priority:** in RUN assert `stop` on the same cycle the advance would occur → next cycle `sel`=00, `busy`=0, `step`=0; `stop`+`start` together in IDLE → enters RUN.
- **Dwell latching:** change `dwell` from 1 to 7 mid-scan → the period stays 2 cycles per code until stop and restart, after which it is 8 cycles per code.

Source files
------------

// File: rtl/scan_select_pkg.sv
// rtl/scan_select_pkg.sv - shared types and code constants for the select scanner
package scan_select_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [1:0] SEL_FIRST = 2'b00;

  localparam logic [1:0] GRAY_0 = 2'b00;
  localparam logic [1:0] GRAY_1 = 2'b01;
  localparam logic [1:0] GRAY_2 = 2'b11;
  localparam logic [1:0] GRAY_3 = 2'b10;

endpackage

// File: rtl/scan_select_seq_if.sv
// rtl/scan_select_seq_if.sv - control and select bundle between a controller and the scanner
interface scan_select_seq_if #(
  parameter int DWELL_W = 8
);
  logic               start;
  logic               stop;
  logic               en;
  logic [DWELL_W-1:0] dwell;
  logic [1:0]         sel;
  logic               step;
  logic               wrap;
  logic               busy;

  modport master (
    output start, stop, en, dwell,
    input  sel, step, wrap, busy
  );

  modport slave (
    input  start, stop, en, dwell,
    output sel, step, wrap, busy
  );
endinterface

// File: rtl/scan_code_map.sv
// rtl/scan_code_map.sv - index to select-code mapping; SCAN_GRAY_EN selects Gray order,
// otherwise the code equals the index.
module scan_code_map
  import scan_select_pkg::*;
(
  input  logic [1:0] idx_i,
  output logic [1:0] code_o
);

  always_comb begin
    code_o = SEL_FIRST;
`ifdef SCAN_GRAY_EN
    case (idx_i)
      2'd0:    code_o = GRAY_0;
      2'd1:    code_o = GRAY_1;
      2'd2:    code_o = GRAY_2;
      default: code_o = GRAY_3;
    endcase
`else
    code_o = idx_i;
`endif
  end

endmodule

// File: rtl/scan_select_seq.sv
// rtl/scan_select_seq.sv - steps a 2-bit decoder select through four codes with a
// programmable dwell, start/stop control, pause and step/wrap strobes.
module scan_select_seq
  import scan_select_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  scan_select_seq_if.slave bus
);

  state_e             state_q;
  logic [1:0]         idx_q;
  logic [1:0]         idx_d;
  logic [1:0]         code_d;
  logic [DWELL_W-1:0] cnt_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [1:0]         sel_q;
  logic               step_q;
  logic               wrap_q;
  logic               busy_q;

  assign idx_d = idx_q + 2'd1;

  // Map the upcoming index so sel_q lands on the new code in the same edge as step.
  scan_code_map u_code_map (
    .idx_i  (idx_d),
    .code_o (code_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= 2'd0;
      cnt_q   <= '0;
      dwell_q <= '0;
      sel_q   <= SEL_FIRST;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          idx_q  <= 2'd0;
          cnt_q  <= '0;
          sel_q  <= SEL_FIRST;
          step_q <= 1'b0;
          wrap_q <= 1'b0;
          if (bus.start) begin
            state_q <= ST_RUN;
            dwell_q <= bus.dwell;
            busy_q  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (bus.stop) begin
            state_q <= ST_IDLE;
            idx_q   <= 2'd0;
            cnt_q   <= '0;
            sel_q   <= SEL_FIRST;
            step_q  <= 1'b0;
            wrap_q  <= 1'b0;
            busy_q  <= 1'b0;
          end else if (!bus.en) begin
            step_q <= 1'b0;
            wrap_q <= 1'b0;
          end else if (cnt_q == dwell_q) begin
            cnt_q  <= '0;
            idx_q  <= idx_d;
            sel_q  <= code_d;
            step_q <= 1'b1;
            wrap_q <= (idx_q == 2'd3);
          end else begin
            cnt_q  <= cnt_q + 1'b1;
            step_q <= 1'b0;
            wrap_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.sel  = sel_q;
  assign bus.step = step_q;
  assign bus.wrap = wrap_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_scan_select_seq.sv
// tb/tb_scan_select_seq.sv - directed self-checking bench for scan_select_seq
module tb_scan_select_seq;

  localparam int DWELL_W = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  scan_select_seq_if #(.DWELL_W(DWELL_W)) bus ();

  scan_select_seq #(.DWELL_W(DWELL_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] exp_code(input int i);
    logic [1:0] c;
`ifdef SCAN_GRAY_EN
    case (i % 4)
      0:       c = 2'b00;
      1:       c = 2'b01;
      2:       c = 2'b11;
      default: c = 2'b10;
    endcase
`else
    c = 2'((i % 4));
`endif
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int dw);
    bus.dwell = DWELL_W'(dw);
    bus.en    = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic do_stop();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
  endtask

  task automatic test_reset();
    bit found;
    rst = 1'b1;
    bus.start = 1'b0; bus.stop = 1'b0; bus.en = 1'b0; bus.dwell = '0;
    tick(); tick();
    n_checks++; if (bus.sel !== 2'b00) $display("FAIL reset_sel got %b expected 00", bus.sel); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b expected 0", bus.busy); else n_pass++;
    n_checks++; if (bus.step !== 1'b0) $display("FAIL reset_step got %b expected 0", bus.step); else n_pass++;
    n_checks++; if (bus.wrap !== 1'b0) $display("FAIL reset_wrap got %b expected 0", bus.wrap); else n_pass++;
    rst = 1'b0;
    tick();
    do_start(0);
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      tick();
      if (bus.sel === 2'b11) found = 1'b1;
    end
    n_checks++; if (!found) $display("FAIL reset_reach_sel11 got %b expected 11", bus.sel); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (bus.sel !== 2'b00) $display("FAIL async_rst_sel got %b expected 00", bus.sel); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL async_rst_busy got %b expected 0", bus.busy); else n_pass++;
    n_checks++; if (bus.step !== 1'b0) $display("FAIL async_rst_step got %b expected 0", bus.step); else n_pass++;
    n_checks++; if (bus.wrap !== 1'b0) $display("FAIL async_rst_wrap got %b expected 0", bus.wrap); else n_pass++;
    bus.start = 1'b1;
    tick(); tick();
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL rst_held_busy got %b expected 0", bus.busy); else n_pass++;
    n_checks++; if (bus.sel !== 2'b00) $display("FAIL rst_held_sel got %b expected 00", bus.sel); else n_pass++;
    bus.start = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_scan_dwell3();
    do_start(3);
    n_checks++; if (bus.busy !== 1'b1) $display("FAIL d3_busy got %b expected 1", bus.busy); else n_pass++;
    for (int k = 1; k <= 17; k++) begin
      tick();
      n_checks++; if (bus.sel !== exp_code(k / 4)) $display("FAIL d3_sel k=%0d got %b expected %b", k, bus.sel, exp_code(k / 4)); else n_pass++;
      n_checks++; if (bus.step !== (k % 4 == 0)) $display("FAIL d3_step k=%0d got %b expected %b", k, bus.step, (k % 4 == 0)); else n_pass++;
      n_checks++; if (bus.wrap !== (k == 16)) $display("FAIL d3_wrap k=%0d got %b expected %b", k, bus.wrap, (k == 16)); else n_pass++;
    end
    do_stop();
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL d3_stop_busy got %b expected 0", bus.busy); else n_pass++;
  endtask

  task automatic test_scan_dwell0();
    do_start(0);
    for (int k = 1; k <= 9; k++) begin
      tick();
      n_checks++; if (bus.sel !== exp_code(k)) $display("FAIL d0_sel k=%0d got %b expected %b", k, bus.sel, exp_code(k)); else n_pass++;
      n_checks++; if (bus.step !== 1'b1) $display("FAIL d0_step k=%0d got %b expected 1", k, bus.step); else n_pass++;
      n_checks++; if (bus.wrap !== (k % 4 == 0)) $display("FAIL d0_wrap k=%0d got %b expected %b", k, bus.wrap, (k % 4 == 0)); else n_pass++;
    end
    do_stop();
  endtask

  task automatic test_pause();
    do_start(2);
    tick();
    n_checks++; if (bus.step !== 1'b0) $display("FAIL pause_pre_step got %b expected 0", bus.step); else n_pass++;
    bus.en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++; if (bus.sel !== exp_code(0)) $display("FAIL pause_sel k=%0d got %b expected %b", k, bus.sel, exp_code(0)); else n_pass++;
      n_checks++; if (bus.step !== 1'b0 || bus.wrap !== 1'b0) $display("FAIL pause_pulse k=%0d got %b%b expected 00", k, bus.step, bus.wrap); else n_pass++;
      n_checks++; if (bus.busy !== 1'b1) $display("FAIL pause_busy k=%0d got %b expected 1", k, bus.busy); else n_pass++;
    end
    bus.en = 1'b1;
    tick();
    n_checks++; if (bus.step !== 1'b0 || bus.sel !== exp_code(0)) $display("FAIL pause_resume got sel=%b step=%b expected sel=%b step=0", bus.sel, bus.step, exp_code(0)); else n_pass++;
    tick();
    n_checks++; if (bus.step !== 1'b1 || bus.sel !== exp_code(1)) $display("FAIL pause_advance got sel=%b step=%b expected sel=%b step=1", bus.sel, bus.step, exp_code(1)); else n_pass++;
    tick(); tick();
    n_checks++; if (bus.step !== 1'b0) $display("FAIL pause_next_early got %b expected 0", bus.step); else n_pass++;
    tick();
    n_checks++; if (bus.step !== 1'b1 || bus.sel !== exp_code(2)) $display("FAIL pause_next_step got sel=%b step=%b expected sel=%b step=1", bus.sel, bus.step, exp_code(2)); else n_pass++;
    do_stop();
  endtask

  task automatic test_stop_priority();
    do_start(1);
    tick();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    n_checks++; if (bus.sel !== 2'b00) $display("FAIL stop_sel got %b expected 00", bus.sel); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL stop_busy got %b expected 0", bus.busy); else n_pass++;
    n_checks++; if (bus.step !== 1'b0) $display("FAIL stop_step got %b expected 0", bus.step); else n_pass++;
    bus.start = 1'b1; bus.stop = 1'b1;
    tick();
    bus.start = 1'b0; bus.stop = 1'b0;
    n_checks++; if (bus.busy !== 1'b1) $display("FAIL start_stop_idle_busy got %b expected 1", bus.busy); else n_pass++;
    tick(); tick();
    n_checks++; if (bus.step !== 1'b1 || bus.sel !== exp_code(1)) $display("FAIL start_stop_run got sel=%b step=%b expected sel=%b step=1", bus.sel, bus.step, exp_code(1)); else n_pass++;
    do_stop();
  endtask

  task automatic test_dwell_latch();
    do_start(1);
    bus.dwell = DWELL_W'(7);
    for (int k = 1; k <= 9; k++) begin
      tick();
      n_checks++; if (bus.step !== (k % 2 == 0)) $display("FAIL latch_old_step k=%0d got %b expected %b", k, bus.step, (k % 2 == 0)); else n_pass++;
      n_checks++; if (bus.sel !== exp_code(k / 2)) $display("FAIL latch_old_sel k=%0d got %b expected %b", k, bus.sel, exp_code(k / 2)); else n_pass++;
      n_checks++; if (bus.wrap !== (k == 8)) $display("FAIL latch_old_wrap k=%0d got %b expected %b", k, bus.wrap, (k == 8)); else n_pass++;
    end
    do_stop();
    do_start(7);
    for (int k = 1; k <= 9; k++) begin
      tick();
      n_checks++; if (bus.step !== (k == 8)) $display("FAIL latch_new_step k=%0d got %b expected %b", k, bus.step, (k == 8)); else n_pass++;
      n_checks++; if (bus.sel !== exp_code(k / 8)) $display("FAIL latch_new_sel k=%0d got %b expected %b", k, bus.sel, exp_code(k / 8)); else n_pass++;
    end
    do_stop();
  endtask

  initial begin
    test_reset();
    test_scan_dwell3();
    test_scan_dwell0();
    test_pause();
    test_stop_priority();
    test_dwell_latch();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
